// File: rtl/fb_pkg.sv
// Shared constants, entity field layout and helpers for the frame-buffer sprite pipe.
// The FB_FRAME_LATCH_EN macro is consumed by fb_sprite_pipe.
package fb_pkg;

    localparam int ENTITY_W   = 14;
    localparam int ID_W       = 4;
    localparam int ID_LSB     = 10;
    localparam int ORIENT_W   = 2;
    localparam int ORIENT_LSB = 8;
    localparam int ROW_W      = 4;
    localparam int ROW_LSB    = 4;
    localparam int COL_W      = 4;
    localparam int COL_LSB    = 0;

    localparam logic [ID_W-1:0] ENTITY_UNUSED_ID = 4'hF;

    localparam logic [ORIENT_W-1:0] ORIENT_0   = 2'd0;
    localparam logic [ORIENT_W-1:0] ORIENT_90  = 2'd1;
    localparam logic [ORIENT_W-1:0] ORIENT_180 = 2'd2;
    localparam logic [ORIENT_W-1:0] ORIENT_270 = 2'd3;

    localparam int DEF_TILE_PX = 8;
    localparam int DEF_UPSCALE = 5;
    localparam int DEF_TILES_H = 16;
    localparam int DEF_TILES_V = 12;

    typedef struct packed {
        logic [ID_W-1:0]     id;
        logic [ORIENT_W-1:0] orient;
        logic [ROW_W-1:0]    row;
        logic [COL_W-1:0]    col;
    } entity_t;

    function automatic int tile_len_px(input int tile_px, input int upscale);
        return tile_px * upscale;
    endfunction

endpackage

// File: rtl/fb_entity_hit.sv
// Combinational coverage test of one entity channel against the current tile.
// Tile coordinates arrive pre-divided from the pixel counters.
module fb_entity_hit
    import fb_pkg::*;
#(
    parameter int TILES_V = DEF_TILES_V
) (
    input  logic [ENTITY_W-1:0] i_entity,
    input  logic [9:0]          i_tile_x,
    input  logic [9:0]          i_tile_y,
    output logic                o_covered,
    output logic [ID_W-1:0]     o_id,
    output logic [ORIENT_W-1:0] o_orient
);

    entity_t w_ent;
    logic    w_used;
    logic    w_row_ok;

    assign w_ent    = i_entity;
    assign w_used   = (w_ent.id != ENTITY_UNUSED_ID);
    assign w_row_ok = (int'(w_ent.row) < TILES_V);

    assign o_covered = w_used && w_row_ok
                    && ({6'd0, w_ent.col} == i_tile_x)
                    && ({6'd0, w_ent.row} == i_tile_y);
    assign o_id      = w_ent.id;
    assign o_orient  = w_ent.orient;

endmodule

// File: rtl/fb_sprite_pipe.sv
// Pipelined sprite colour path: detect, ROM read, pixel select at 2+ROM_LATENCY cycles.
// Define FB_FRAME_LATCH_EN to detect against an entity snapshot taken at frame start.
module fb_sprite_pipe
    import fb_pkg::*;
#(
    parameter int   NUM_ENTITIES = 6,
    parameter int   TILE_PX      = DEF_TILE_PX,
    parameter int   UPSCALE      = DEF_UPSCALE,
    parameter int   TILES_H      = DEF_TILES_H,
    parameter int   TILES_V      = DEF_TILES_V,
    parameter int   ROM_LATENCY  = 1,
    parameter logic BG_COLOUR    = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ENTITY_W*NUM_ENTITIES-1:0] entity_bus,
    input  logic [9:0]                       counter_H,
    input  logic [9:0]                       counter_V,
    output logic                             rom_rd_en,
    output logic [3:0]                       rom_sprite_id,
    output logic [1:0]                       rom_orientation,
    output logic [2:0]                       rom_line,
    input  logic [7:0]                       rom_data,
    output logic                             colour,
    output logic                             hit,
    output logic                             collision
);

    localparam int         TILE_LEN = tile_len_px(TILE_PX, UPSCALE);
    localparam logic [9:0] LEN_W    = 10'(TILE_LEN);
    localparam logic [9:0] UPS_W    = 10'(UPSCALE);
    localparam logic [9:0] SCR_W    = 10'(TILES_H * TILE_LEN);
    localparam logic [9:0] SCR_H    = 10'(TILES_V * TILE_LEN);

    logic [ENTITY_W*NUM_ENTITIES-1:0] w_bus;

`ifdef FB_FRAME_LATCH_EN
    logic [ENTITY_W*NUM_ENTITIES-1:0] r_shadow;

    // All-ones shadow marks every channel unused until the first frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '1;
        end else if (counter_H == 10'd0 && counter_V == 10'd0) begin
            r_shadow <= entity_bus;
        end
    end

    assign w_bus = r_shadow;
`else
    assign w_bus = entity_bus;
`endif

    logic [9:0] w_tile_x;
    logic [9:0] w_tile_y;
    logic [2:0] w_px_col;
    logic [2:0] w_px_line;
    logic       w_vis;

    assign w_tile_x  = counter_H / LEN_W;
    assign w_tile_y  = counter_V / LEN_W;
    assign w_px_col  = 3'((counter_H % LEN_W) / UPS_W);
    assign w_px_line = 3'((counter_V % LEN_W) / UPS_W);
    assign w_vis     = (counter_H < SCR_W) && (counter_V < SCR_H);

    logic [NUM_ENTITIES-1:0] w_cov;
    logic [3:0]              w_ids [NUM_ENTITIES];
    logic [1:0]              w_ors [NUM_ENTITIES];

    for (genvar k = 0; k < NUM_ENTITIES; k++) begin : g_ent
        fb_entity_hit #(
            .TILES_V (TILES_V)
        ) u_hit (
            .i_entity  (w_bus[ENTITY_W*k +: ENTITY_W]),
            .i_tile_x  (w_tile_x),
            .i_tile_y  (w_tile_y),
            .o_covered (w_cov[k]),
            .o_id      (w_ids[k]),
            .o_orient  (w_ors[k])
        );
    end

    logic [3:0] w_win_id;
    logic [1:0] w_win_or;
    logic [4:0] w_cnt;
    logic       w_hit;
    logic       w_coll;

    // Walk from the top channel down so the lowest covering index wins.
    always_comb begin
        w_win_id = '0;
        w_win_or = '0;
        w_cnt    = '0;
        for (int k = NUM_ENTITIES - 1; k >= 0; k--) begin
            if (w_cov[k]) begin
                w_win_id = w_ids[k];
                w_win_or = w_ors[k];
            end
        end
        for (int k = 0; k < NUM_ENTITIES; k++) begin
            w_cnt = w_cnt + {4'd0, w_cov[k]};
        end
    end

    assign w_hit  = w_vis && (w_cnt != 5'd0);
    assign w_coll = w_vis && (w_cnt >= 5'd2);

    logic       r_d_hit;
    logic       r_d_coll;
    logic [3:0] r_d_id;
    logic [1:0] r_d_or;
    logic [2:0] r_d_line;
    logic [2:0] r_d_col;
    logic       r_d_vis;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_hit  <= 1'b0;
            r_d_coll <= 1'b0;
            r_d_id   <= '0;
            r_d_or   <= '0;
            r_d_line <= '0;
            r_d_col  <= '0;
            r_d_vis  <= 1'b0;
        end else begin
            r_d_hit  <= w_hit;
            r_d_coll <= w_coll;
            r_d_id   <= w_win_id;
            r_d_or   <= w_win_or;
            r_d_line <= w_px_line;
            r_d_col  <= w_px_col;
            r_d_vis  <= w_vis;
        end
    end

    assign rom_rd_en       = r_d_hit;
    assign rom_sprite_id   = r_d_hit ? r_d_id   : 4'd0;
    assign rom_orientation = r_d_hit ? r_d_or   : 2'd0;
    assign rom_line        = r_d_hit ? r_d_line : 3'd0;

    logic [2:0]             r_p_col [ROM_LATENCY];
    logic [ROM_LATENCY-1:0] r_p_hit;
    logic [ROM_LATENCY-1:0] r_p_coll;
    logic [ROM_LATENCY-1:0] r_p_vis;

    // Sideband delay line matching the ROM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_p_col[i] <= '0;
            end
            r_p_hit  <= '0;
            r_p_coll <= '0;
            r_p_vis  <= '0;
        end else begin
            r_p_col[0]  <= r_d_col;
            r_p_hit[0]  <= r_d_hit;
            r_p_coll[0] <= r_d_coll;
            r_p_vis[0]  <= r_d_vis;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_p_col[i]  <= r_p_col[i-1];
                r_p_hit[i]  <= r_p_hit[i-1];
                r_p_coll[i] <= r_p_coll[i-1];
                r_p_vis[i]  <= r_p_vis[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            colour    <= 1'b0;
            hit       <= 1'b0;
            collision <= 1'b0;
        end else begin
            if (!r_p_vis[ROM_LATENCY-1]) begin
                colour <= 1'b0;
            end else if (r_p_hit[ROM_LATENCY-1]) begin
                colour <= rom_data[r_p_col[ROM_LATENCY-1]];
            end else begin
                colour <= BG_COLOUR;
            end
            hit       <= r_p_hit[ROM_LATENCY-1];
            collision <= r_p_coll[ROM_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_fb_sprite_pipe.sv
// Directed bench for fb_sprite_pipe with hand-computed expectations.
// Define FB_FRAME_LATCH_EN to exercise the frame-start snapshot path.
module tb_fb_sprite_pipe;

    localparam int N = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [14*N-1:0] entity_bus;
    logic [9:0]    counter_H;
    logic [9:0]    counter_V;
    logic          rom_rd_en;
    logic [3:0]    rom_sprite_id;
    logic [1:0]    rom_orientation;
    logic [2:0]    rom_line;
    logic [7:0]    rom_data;
    logic          colour;
    logic          hit;
    logic          collision;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fb_sprite_pipe dut (
        .clk             (clk),
        .reset           (reset),
        .entity_bus      (entity_bus),
        .counter_H       (counter_H),
        .counter_V       (counter_V),
        .rom_rd_en       (rom_rd_en),
        .rom_sprite_id   (rom_sprite_id),
        .rom_orientation (rom_orientation),
        .rom_line        (rom_line),
        .rom_data        (rom_data),
        .colour          (colour),
        .hit             (hit),
        .collision       (collision)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14*N-1:0] ch(input logic [14*N-1:0] b,
                                          input int k,
                                          input logic [13:0] e);
        logic [14*N-1:0] r;
        r = b;
        r[14*k +: 14] = e;
        return r;
    endfunction

    // Blank filler pixel between directed pixels.
    task automatic blank();
        counter_H = 10'd700;
        counter_V = 10'd10;
    endtask

    // Apply a new bus at frame start, then flush the pipe with blank pixels.
    task automatic load(input logic [14*N-1:0] b);
        entity_bus = b;
        counter_H  = 10'd0;
        counter_V  = 10'd0;
        step();
        blank();
        step();
        step();
        step();
    endtask

    // Present one pixel for one cycle; on return the D stage holds it.
    task automatic run(input logic [9:0] h, input logic [9:0] v);
        counter_H = h;
        counter_V = v;
        step();
        blank();
    endtask

    task automatic out3(input string tag, input logic c,
                        input logic h, input logic k);
        chk({tag, ".colour"}, 8'(colour), 8'(c));
        chk({tag, ".hit"}, 8'(hit), 8'(h));
        chk({tag, ".coll"}, 8'(collision), 8'(k));
    endtask

    logic [14*N-1:0] b;

    initial begin
        reset      = 1'b1;
        entity_bus = '1;
        rom_data   = 8'h00;
        blank();
        step();
        step();
        out3("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.rd_en", 8'(rom_rd_en), 8'd0);
        chk("rst.id", 8'(rom_sprite_id), 8'd0);
        reset = 1'b0;

        b = ch('1, 0, {4'h2, 2'b01, 8'h23});
        load(b);
        rom_data = 8'b0000_0010;
        run(10'd125, 10'd87);
        chk("basic.rd_en", 8'(rom_rd_en), 8'd1);
        chk("basic.id", 8'(rom_sprite_id), 8'd2);
        chk("basic.or", 8'(rom_orientation), 8'd1);
        chk("basic.line", 8'(rom_line), 8'd1);
        step();
        chk("basic.lat", 8'(hit), 8'd0);
        step();
        out3("basic", 1'b1, 1'b1, 1'b0);

        rom_data = 8'hFD;
        run(10'd125, 10'd87);
        step();
        step();
        out3("basic0", 1'b0, 1'b1, 1'b0);

        b = ch('1, 0, {4'h5, 2'b00, 8'h00});
        b = ch(b, 3, {4'h7, 2'b10, 8'h00});
        load(b);
        rom_data = 8'h01;
        run(10'd3, 10'd0);
        chk("prio.id", 8'(rom_sprite_id), 8'd5);
        chk("prio.or", 8'(rom_orientation), 8'd0);
        step();
        step();
        out3("prio", 1'b1, 1'b1, 1'b1);

        b = ch('1, 3, {4'h7, 2'b10, 8'h00});
        load(b);
        run(10'd3, 10'd0);
        chk("ch3.id", 8'(rom_sprite_id), 8'd7);
        chk("ch3.or", 8'(rom_orientation), 8'd2);
        step();
        step();
        out3("ch3", 1'b1, 1'b1, 1'b0);

        load('1);
        run(10'd200, 10'd200);
        chk("bg.rd_en", 8'(rom_rd_en), 8'd0);
        chk("bg.id", 8'(rom_sprite_id), 8'd0);
        step();
        step();
        out3("bg", 1'b1, 1'b0, 1'b0);

        b = ch('1, 0, {4'h2, 2'b00, 8'h0F});
        load(b);
        rom_data = 8'h00;
        run(10'd700, 10'd10);
        chk("blank.rd_en", 8'(rom_rd_en), 8'd0);
        step();
        step();
        out3("blank", 1'b0, 1'b0, 1'b0);
        run(10'd620, 10'd10);
        chk("c15.rd_en", 8'(rom_rd_en), 8'd1);
        chk("c15.line", 8'(rom_line), 8'd2);
        step();
        step();
        out3("c15", 1'b0, 1'b1, 1'b0);

        b = ch('1, 0, {4'h3, 2'b11, 8'hBF});
        load(b);
        rom_data = 8'h80;
        run(10'd639, 10'd479);
        chk("corner.line", 8'(rom_line), 8'd7);
        chk("corner.or", 8'(rom_orientation), 8'd3);
        step();
        step();
        out3("corner", 1'b1, 1'b1, 1'b0);
        run(10'd640, 10'd479);
        chk("h640.rd_en", 8'(rom_rd_en), 8'd0);

        b = ch('1, 0, {4'h4, 2'b00, 8'hC0});
        load(b);
        run(10'd0, 10'd490);
        chk("row12.rd_en", 8'(rom_rd_en), 8'd0);

        b = ch('1, 0, {4'h2, 2'b01, 8'h23});
        load(b);
        rom_data  = 8'b0000_0010;
        counter_H = 10'd125;
        counter_V = 10'd87;
        step();
        step();
        step();
        out3("pre_rst", 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        out3("rst_mid", 1'b0, 1'b0, 1'b0);
        chk("rst_mid.rd_en", 8'(rom_rd_en), 8'd0);
        reset = 1'b0;
        step();
        out3("fill1", 1'b0, 1'b0, 1'b0);
        step();
        out3("fill2", 1'b0, 1'b0, 1'b0);
        step();
`ifdef FB_FRAME_LATCH_EN
        out3("release", 1'b1, 1'b0, 1'b0);
`else
        out3("release", 1'b1, 1'b1, 1'b0);
`endif
        blank();

        b = ch('1, 0, {4'h2, 2'b00, 8'h00});
        load(b);
        entity_bus = ch('1, 0, {4'h2, 2'b00, 8'h01});
`ifdef FB_FRAME_LATCH_EN
        run(10'd45, 10'd0);
        chk("latch.old1", 8'(rom_rd_en), 8'd0);
        run(10'd5, 10'd0);
        chk("latch.old0", 8'(rom_rd_en), 8'd1);
        run(10'd0, 10'd0);
        run(10'd45, 10'd0);
        chk("latch.new1", 8'(rom_rd_en), 8'd1);
        run(10'd5, 10'd0);
        chk("latch.new0", 8'(rom_rd_en), 8'd0);
`else
        run(10'd45, 10'd0);
        chk("live.new1", 8'(rom_rd_en), 8'd1);
        run(10'd5, 10'd0);
        chk("live.new0", 8'(rom_rd_en), 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fb_sprite_pipe.md
Name: fb_sprite_pipe

Overview:
- Parametrised, pipelined successor to the single-stage frame-buffer colour path.
- Takes NUM_ENTITIES packed entity channels and the VGA pixel counters, and picks the highest-priority entity covering the current pixel.
- Issues a sprite-ROM line read, then selects the pixel bit, producing a registered monochrome colour plus hit/collision flags at fixed latency.
- Sits between the game-logic entity registers and the VGA output stage.

Parameters:
- NUM_ENTITIES, 6, number of entity channels (1..16).
- TILE_PX, 8, sprite edge in source pixels.
- UPSCALE, 5, screen pixels per sprite pixel; tile edge = TILE_PX*UPSCALE = 40.
- TILES_H, 16, tiles per row; visible width = TILES_H*40 = 640.
- TILES_V, 12, tile rows; visible height = 480.
- ROM_LATENCY, 1, cycles from rom_rd_en to valid rom_data (>=1).
- BG_COLOUR, 1, colour of a visible pixel with no hit.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- entity_bus  in  14*NUM_ENTITIES  channel k at [14k+13:14k]. Fields: [13:10] sprite ID (4'hF = unused), [9:8] orientation, [7:4] tile row, [3:0] tile column.
- counter_H  in  10  horizontal pixel counter.
- counter_V  in  10  vertical pixel counter.
- rom_rd_en  out  1  ROM read strobe.
- rom_sprite_id  out  4  sprite ID to ROM.
- rom_orientation  out  2  orientation to ROM.
- rom_line  out  3  sprite line index to ROM.
- rom_data  in  8  sprite line; bit i = sprite column i.
- colour  out  1  0 = black, 1 = white.
- hit  out  1  pixel covered by at least one entity, aligned with colour.
- collision  out  1  at least two entities cover the pixel, aligned with colour.

Behaviour:
- Visible pixel: counter_H < 640 and counter_V < 480. Non-visible: colour=0, hit=0, collision=0.
- Coverage of channel k: ID != 4'hF, tile row < TILES_V, counter_H/40 == col, counter_V/40 == row.
- Divisions and modulos are by constants and are computed combinationally on the 10-bit counters.
- Priority: the lowest channel index wins. collision = popcount(covering) >= 2.
- Stage D, cycle N+1, registers:
  - hit, collision, winner ID and orientation
  - line = (counter_V%40)/UPSCALE
  - col = (counter_H%40)/UPSCALE
  - visible flag
- Stage R, driven from the D registers:
  - rom_rd_en = D.hit.
  - rom_sprite_id, rom_orientation and rom_line come from the D registers.
  - When D.hit=0, rom_* are held at 0.
- col, hit, collision and visible travel a ROM_LATENCY-deep shift register alongside the read.
- Stage C, cycle N+2+ROM_LATENCY:
  - colour = !visible ? 0 : hit ? rom_data[col] : BG_COLOUR
  - hit and collision are registered in the same cycle.
- Total latency is 2+ROM_LATENCY cycles (3 at default). The pipeline advances every cycle with no stall; there is no back-pressure.
- Reset: every pipeline register, colour, hit, collision, rom_rd_en and rom_* clear to 0.
  - After reset release, outputs stay 0 for 2+ROM_LATENCY cycles while the pipe fills.
  - Reset mid-frame discards all in-flight pixels.
- Simultaneous ID change and pixel: the value sampled in cycle N applies to pixel N only.
- Tile row >= TILES_V never matches. Column field is 4 bits, so it is always in range when TILES_H=16.
- orientation is passed through only; the ROM applies rotation.

Optional Feature:
- Macro FB_FRAME_LATCH_EN.
- Defined: entity_bus is captured into a shadow register on the cycle where counter_H==0 and counter_V==0, and all detection uses the shadow copy, giving tear-free frames. The shadow resets to all-ones (every channel unused).
- Undefined: entity_bus is used live every cycle, and no shadow register exists.

Decomposition:
- Package fb_pkg holds:
  - entity field widths and offsets
  - ENTITY_UNUSED_ID = 4'hF
  - orientation localparams
  - ENTITY_W = 14
  - default tile, upscale and screen constants
  - a function computing TILE_LEN_PX
- Sub-module fb_entity_hit: combinational per-channel coverage test. It is instantiated NUM_ENTITIES times via generate and outputs a covered bit plus ID and orientation.
- Priority encode, popcount and pipeline stay in the top module.

Test Plan:
- Basic hit:
  - Stimulus: ch0 = {4'h2,2'b01,8'h23}, H=125, V=87, rom_data=8'b0000_0010 during the read.
  - Response: rom_rd_en=1, id=2, orient=1, line=1; three cycles later colour=1, hit=1, collision=0.
- Priority and collision:
  - Stimulus: ch0 and ch3 both at tile 8'h00 with IDs 5 and 7, H=3, V=0.
  - Response: rom_sprite_id=5, collision=1 at output.
- Unused and background:
  - Stimulus: all IDs 4'hF, H=200, V=200.
  - Response: rom_rd_en=0; colour=1 (BG_COLOUR), hit=0 after 3 cycles.
- Blanking:
  - Stimulus: ch0 at tile 8'h0F, H=700, V=10.
  - Response: colour=0, hit=0.
- Reset mid-stream:
  - Stimulus: assert reset for 1 cycle during a hit sequence.
  - Response: all outputs 0 next cycle and for 3 cycles after release; the first correct pixel is the one presented on the release cycle, appearing 3 cycles later.
- FB_FRAME_LATCH_EN:
  - Stimulus: change ch0 tile from 8'h00 to 8'h01 mid-frame.
  - Response: detection keeps 8'h00 until H=0,V=0 is seen, then uses 8'h01.
